// File: rtl/mips_decode_pkg.sv
// Shared constants for the MIPS54 decode stage: type indices, opcodes and funct codes.
package mips_decode_pkg;

  localparam int unsigned NUM_TYPES = 55;
  localparam int unsigned IDX_W     = 6;
  localparam logic [5:0]  ILLEGAL_IDX = 6'd63;

  // Type indices double as one-hot bit positions
  localparam logic [5:0] T_ADD   = 6'd0,  T_ADDU  = 6'd1,  T_SUB   = 6'd2,  T_SUBU  = 6'd3;
  localparam logic [5:0] T_AND   = 6'd4,  T_OR    = 6'd5,  T_XOR   = 6'd6,  T_NOR   = 6'd7;
  localparam logic [5:0] T_SLT   = 6'd8,  T_SLTU  = 6'd9,  T_SLL   = 6'd10, T_SRL   = 6'd11;
  localparam logic [5:0] T_SRA   = 6'd12, T_SLLV  = 6'd13, T_SRLV  = 6'd14, T_SRAV  = 6'd15;
  localparam logic [5:0] T_JR    = 6'd16, T_ADDI  = 6'd17, T_ADDIU = 6'd18, T_ANDI  = 6'd19;
  localparam logic [5:0] T_ORI   = 6'd20, T_XORI  = 6'd21, T_LUI   = 6'd22, T_LW    = 6'd23;
  localparam logic [5:0] T_SW    = 6'd24, T_BEQ   = 6'd25, T_BNE   = 6'd26, T_SLTI  = 6'd27;
  localparam logic [5:0] T_SLTIU = 6'd28, T_J     = 6'd29, T_JAL   = 6'd30, T_DIV   = 6'd31;
  localparam logic [5:0] T_DIVU  = 6'd32, T_MULT  = 6'd33, T_MULTU = 6'd34, T_BGEZ  = 6'd35;
  localparam logic [5:0] T_JALR  = 6'd36, T_LBU   = 6'd37, T_LHU   = 6'd38, T_LB    = 6'd39;
  localparam logic [5:0] T_LH    = 6'd40, T_SB    = 6'd41, T_SH    = 6'd42, T_BREAK = 6'd43;
  localparam logic [5:0] T_SYSCALL = 6'd44, T_ERET = 6'd45, T_MFHI = 6'd46, T_MFLO  = 6'd47;
  localparam logic [5:0] T_MTHI  = 6'd48, T_MTLO  = 6'd49, T_MFC0  = 6'd50, T_MTC0  = 6'd51;
  localparam logic [5:0] T_CLZ   = 6'd52, T_TEQ   = 6'd53, T_MUL   = 6'd54;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_COP0 = 6'h10, OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E, OP_LUI   = 6'h0F, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_LW   = 6'h23, OP_SW    = 6'h2B, OP_LBU  = 6'h24, OP_LHU  = 6'h25;
  localparam logic [5:0] OP_LB   = 6'h20, OP_LH    = 6'h21, OP_SB   = 6'h28, OP_SH   = 6'h29;
  localparam logic [5:0] OP_BEQ  = 6'h04, OP_BNE   = 6'h05, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BGEZ = 6'h01;

  // Funct codes (SPECIAL, COP0 and SPECIAL2 spaces)
  localparam logic [5:0] FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A, FN_SLTU = 6'h2B, FN_SLL  = 6'h00, FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03, FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08, FN_JALR = 6'h09, FN_DIV  = 6'h1A, FN_DIVU = 6'h1B;
  localparam logic [5:0] FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_BREAK = 6'h0D, FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_MFHI = 6'h10, FN_MFLO = 6'h12, FN_MTHI = 6'h11, FN_MTLO = 6'h13;
  localparam logic [5:0] FN_TEQ  = 6'h34, FN_ERET = 6'h18, FN_MXC0 = 6'h00;
  localparam logic [5:0] FN_CLZ  = 6'h20, FN_MUL  = 6'h02;

endpackage

// File: rtl/mips_type_rom.sv
// Combinational instruction classifier: instruction word to type index, one-hot and illegal flag.
module mips_type_rom
  import mips_decode_pkg::*;
(
  input  logic [31:0]          instr_i,
  output logic [NUM_TYPES-1:0] onehot,
  output logic [IDX_W-1:0]     idx,
  output logic                 illegal
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       c0;
  logic       unused_instr_bits;

  assign op    = instr_i[31:26];
  assign funct = instr_i[5:0];
  assign c0    = instr_i[23];
  assign unused_instr_bits = ^{instr_i[25:24], instr_i[22:6]};

  // Table lookup; anything without a match keeps the illegal index
  always_comb begin
    idx = ILLEGAL_IDX;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          FN_ADD:  idx = T_ADD;   FN_ADDU:  idx = T_ADDU;  FN_SUB:   idx = T_SUB;
          FN_SUBU: idx = T_SUBU;  FN_AND:   idx = T_AND;   FN_OR:    idx = T_OR;
          FN_XOR:  idx = T_XOR;   FN_NOR:   idx = T_NOR;   FN_SLT:   idx = T_SLT;
          FN_SLTU: idx = T_SLTU;  FN_SLL:   idx = T_SLL;   FN_SRL:   idx = T_SRL;
          FN_SRA:  idx = T_SRA;   FN_SLLV:  idx = T_SLLV;  FN_SRLV:  idx = T_SRLV;
          FN_SRAV: idx = T_SRAV;  FN_JR:    idx = T_JR;    FN_JALR:  idx = T_JALR;
          FN_DIV:  idx = T_DIV;   FN_DIVU:  idx = T_DIVU;  FN_MULT:  idx = T_MULT;
          FN_MULTU: idx = T_MULTU; FN_BREAK: idx = T_BREAK; FN_SYSCALL: idx = T_SYSCALL;
          FN_MFHI: idx = T_MFHI;  FN_MFLO:  idx = T_MFLO;  FN_MTHI:  idx = T_MTHI;
          FN_MTLO: idx = T_MTLO;  FN_TEQ:   idx = T_TEQ;
          default: idx = ILLEGAL_IDX;
        endcase
      end
      OP_COP0: begin
        case (funct)
          FN_ERET: idx = T_ERET;
          FN_MXC0: idx = c0 ? T_MTC0 : T_MFC0;
          default: idx = ILLEGAL_IDX;
        endcase
      end
      OP_SPECIAL2: begin
        case (funct)
          FN_CLZ:  idx = T_CLZ;
          FN_MUL:  idx = T_MUL;
          default: idx = ILLEGAL_IDX;
        endcase
      end
      OP_ADDI:  idx = T_ADDI;   OP_ADDIU: idx = T_ADDIU;  OP_ANDI: idx = T_ANDI;
      OP_ORI:   idx = T_ORI;    OP_XORI:  idx = T_XORI;   OP_LUI:  idx = T_LUI;
      OP_SLTI:  idx = T_SLTI;   OP_SLTIU: idx = T_SLTIU;  OP_LW:   idx = T_LW;
      OP_SW:    idx = T_SW;     OP_LBU:   idx = T_LBU;    OP_LHU:  idx = T_LHU;
      OP_LB:    idx = T_LB;     OP_LH:    idx = T_LH;     OP_SB:   idx = T_SB;
      OP_SH:    idx = T_SH;     OP_BEQ:   idx = T_BEQ;    OP_BNE:  idx = T_BNE;
      OP_J:     idx = T_J;      OP_JAL:   idx = T_JAL;    OP_BGEZ: idx = T_BGEZ;
      default:  idx = ILLEGAL_IDX;
    endcase
  end

  assign illegal = (idx == ILLEGAL_IDX);
  assign onehot  = illegal ? '0 : (NUM_TYPES'(1) << idx);

endmodule

// File: rtl/mips_decode_stage.sv
// Registered decode stage: classifier followed by a valid/ready register pipeline with flush and illegal counter.
module mips_decode_stage
  import mips_decode_pkg::*;
#(
  parameter int unsigned TAG_W       = 32,
  parameter int unsigned OUT_INDEX   = 0,
  parameter int unsigned PIPE_STAGES = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [31:0]          instr_i,
  input  logic [TAG_W-1:0]     tag_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [NUM_TYPES-1:0] type_o,
  output logic                 illegal_o,
  output logic [TAG_W-1:0]     tag_o,
  output logic [CNT_W-1:0]     illegal_cnt_o
);

  localparam int unsigned LAST = PIPE_STAGES - 1;
  localparam logic [PIPE_STAGES-1:0] ALL_ONES = '1;

  logic [NUM_TYPES-1:0]   rom_onehot;
  logic [IDX_W-1:0]       rom_idx;
  logic                   rom_illegal;
  logic [NUM_TYPES-1:0]   dec_type;

  logic [PIPE_STAGES-1:0] vld_q;
  logic [PIPE_STAGES-1:0] ill_q;
  logic [NUM_TYPES-1:0]   type_q [PIPE_STAGES];
  logic [TAG_W-1:0]       tag_q  [PIPE_STAGES];
  logic [CNT_W-1:0]       cnt_q;

  logic [PIPE_STAGES-1:0] stg_rdy_c;
  logic [PIPE_STAGES-1:0] up_vld_c;
  logic [PIPE_STAGES-1:0] up_ill_c;
  logic [NUM_TYPES-1:0]   up_type_c [PIPE_STAGES];
  logic [TAG_W-1:0]       up_tag_c  [PIPE_STAGES];

  mips_type_rom u_rom (
    .instr_i (instr_i),
    .onehot  (rom_onehot),
    .idx     (rom_idx),
    .illegal (rom_illegal)
  );

  assign dec_type = (OUT_INDEX != 0) ? NUM_TYPES'(rom_idx) : rom_onehot;

  // Stage readiness (a stage frees up if it or any later stage is empty, or the consumer accepts) and upstream payloads
  always_comb begin
    stg_rdy_c = '0;
    up_vld_c  = '0;
    up_ill_c  = '0;
    for (int i = 0; i < PIPE_STAGES; i++) begin
      up_type_c[i] = '0;
      up_tag_c[i]  = '0;
      stg_rdy_c[i] = out_ready_i || (|(~vld_q & (ALL_ONES << i)));
    end
    up_vld_c[0]  = in_valid_i;
    up_ill_c[0]  = rom_illegal;
    up_type_c[0] = dec_type;
    up_tag_c[0]  = tag_i;
    for (int i = 1; i < PIPE_STAGES; i++) begin
      up_vld_c[i]  = vld_q[i-1];
      up_ill_c[i]  = ill_q[i-1];
      up_type_c[i] = type_q[i-1];
      up_tag_c[i]  = tag_q[i-1];
    end
  end

  assign in_ready_o = flush_i || stg_rdy_c[0];

  // Pipeline registers and saturating illegal counter; data loads only on an accepted transfer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      ill_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) begin
        type_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        if (flush_i) begin
          vld_q[i] <= 1'b0;
        end else if (stg_rdy_c[i]) begin
          vld_q[i] <= up_vld_c[i];
          if (up_vld_c[i]) begin
            ill_q[i]  <= up_ill_c[i];
            type_q[i] <= up_type_c[i];
            tag_q[i]  <= up_tag_c[i];
          end
        end
      end
      if (out_valid_o && out_ready_i && illegal_o && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_valid_o   = vld_q[LAST];
  assign illegal_o     = ill_q[LAST];
  assign type_o        = type_q[LAST];
  assign tag_o         = tag_q[LAST];
  assign illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_mips_decode_stage.sv
// Scoreboard bench for mips_decode_stage across three configurations.
module tb_mips_decode_stage;

  localparam int ND = 3;

  typedef struct {
    int          d;
    logic [54:0] ty;
    logic        il;
    logic [31:0] tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n, flush;
  logic [31:0]           instr, tag;
  logic [ND-1:0]         in_valid, out_ready, in_ready, out_valid, illegal;
  logic [ND-1:0][54:0]   type_o;
  logic [ND-1:0][31:0]   tag_o;
  logic [15:0]           cnt0, cnt2;
  logic [1:0]            cnt1;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  exp_t mon_e;

  // d0: one-hot, 1 stage; d1: index mode, 1 stage, 2-bit counter; d2: one-hot, 2 stages
  mips_decode_stage #(.TAG_W(32), .OUT_INDEX(0), .PIPE_STAGES(1), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .instr_i(instr), .tag_i(tag), .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
    .type_o(type_o[0]), .illegal_o(illegal[0]), .tag_o(tag_o[0]), .illegal_cnt_o(cnt0));

  mips_decode_stage #(.TAG_W(32), .OUT_INDEX(1), .PIPE_STAGES(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .instr_i(instr), .tag_i(tag), .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
    .type_o(type_o[1]), .illegal_o(illegal[1]), .tag_o(tag_o[1]), .illegal_cnt_o(cnt1));

  mips_decode_stage #(.TAG_W(32), .OUT_INDEX(0), .PIPE_STAGES(2), .CNT_W(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
    .instr_i(instr), .tag_i(tag), .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]),
    .type_o(type_o[2]), .illegal_o(illegal[2]), .tag_o(tag_o[2]), .illegal_cnt_o(cnt2));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [54:0] exp_ty(input int d, input int idx);
    if (d == 1) return 55'(idx);
    if (idx == 63) return '0;
    return 55'(1) << idx;
  endfunction

  // Offer one instruction to DUT d; expectation is queued when the handshake is seen
  task automatic send(input int d, input logic [31:0] ins, input logic [31:0] tg, input int idx);
    exp_t e;
    bit   ok = 1'b0;
    e.d = d; e.ty = exp_ty(d, idx); e.il = (idx == 63); e.tag = tg;
    instr = ins; tag = tg; in_valid[d] = 1'b1;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (in_ready[d]) begin
        q.push_back(e);
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid[d] = 1'b0;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: dut%0d tag %h never accepted", d, tg);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && q.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  // Monitor: compare every presented output against the scoreboard head; pop on transfer
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < ND; d++) begin
        if (out_valid[d]) begin
          if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_out: dut%0d tag %h type %h", d, tag_o[d], type_o[d]);
          end else begin
            mon_e = q[0];
            chk(out_ready[d] ? "xfer_dut" : "stall_dut", 64'(d), 64'(mon_e.d));
            chk(out_ready[d] ? "xfer_type" : "stall_type", 64'(type_o[d]), 64'(mon_e.ty));
            chk(out_ready[d] ? "xfer_illegal" : "stall_illegal", 64'(illegal[d]), 64'(mon_e.il));
            chk(out_ready[d] ? "xfer_tag" : "stall_tag", 64'(tag_o[d]), 64'(mon_e.tag));
            if (out_ready[d]) void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  logic [31:0] ill_vec [5];
  logic [31:0] bp_ins  [4];
  int          bp_idx  [4];

  initial begin
    ill_vec = '{32'hFC000000, 32'h40000001, 32'h70000000, 32'h0000003F, 32'hFC00ABCD};
    bp_ins  = '{32'h00851020, 32'h8C820004, 32'hAC820004, 32'h08000010};
    bp_idx  = '{0, 23, 24, 29};

    rst_n = 1'b0; flush = 1'b0; in_valid = '0; out_ready = '1; instr = '0; tag = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int d = 0; d < ND; d++) begin
      chk("rst_out_valid", 64'(out_valid[d]), 64'd0);
      chk("rst_type", 64'(type_o[d]), 64'd0);
      chk("rst_illegal", 64'(illegal[d]), 64'd0);
      chk("rst_tag", 64'(tag_o[d]), 64'd0);
      chk("rst_in_ready", 64'(in_ready[d]), 64'd1);
    end
    chk("rst_cnt0", 64'(cnt0), 64'd0);
    chk("rst_cnt1", 64'(cnt1), 64'd0);
    chk("rst_cnt2", 64'(cnt2), 64'd0);

    // One-hot decode, single stage
    send(0, 32'h00851020, 32'h1000, 0);
    @(negedge clk);
    chk("latency1_valid", 64'(out_valid[0]), 64'd1);
    chk("latency1_bit0", 64'(type_o[0]), 64'd1);
    @(posedge clk); #1;
    send(0, 32'h42000018, 32'h1004, 45);
    send(0, 32'h40026000, 32'h1008, 50);
    send(0, 32'h40806000, 32'h100C, 51);
    send(0, 32'h00000034, 32'h1010, 53);
    send(0, 32'h8C820004, 32'h1014, 23);
    drain();
    chk("cnt0_before_illegal", 64'(cnt0), 64'd0);
    send(0, 32'hFC000000, 32'h1018, 63);
    drain();
    chk("cnt0_after_illegal", 64'(cnt0), 64'd1);

    // Index mode with 2-bit saturating counter
    send(1, 32'h40026000, 32'h2000, 50);
    send(1, 32'h40806000, 32'h2004, 51);
    send(1, 32'h70821020, 32'h2008, 52);
    send(1, 32'h70821002, 32'h200C, 54);
    for (int i = 0; i < 5; i++) send(1, ill_vec[i], 32'h2100 + 32'(i), 63);
    drain();
    chk("cnt1_saturated", 64'(cnt1), 64'd3);

    // Backpressure on the two-stage pipeline
    out_ready[2] = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(2, bp_ins[i], 32'h100 + 32'(4 * i), bp_idx[i]);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready[2] = 1'b1;
      end
    join
    drain();

    // Flush with two entries in flight; the word offered during flush is dropped
    out_ready[2] = 1'b0;
    send(2, 32'h20420001, 32'h180, 17);
    send(2, 32'h10000000, 32'h184, 25);
    flush = 1'b1; in_valid[2] = 1'b1; instr = 32'h00000000; tag = 32'hDEAD;
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready[2]), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid[2] = 1'b0;
    q.delete();
    chk("flush_out_valid", 64'(out_valid[2]), 64'd0);
    out_ready[2] = 1'b1;
    send(2, 32'h8C820004, 32'h200, 23);
    drain();
    repeat (3) @(posedge clk); #1;
    chk("cnt2_no_illegal", 64'(cnt2), 64'd0);

    // Reset while an illegal entry is held at the output
    out_ready[0] = 1'b0;
    send(0, 32'hFC000000, 32'h300, 63);
    @(negedge clk);
    chk("pre_rst_valid", 64'(out_valid[0]), 64'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_valid", 64'(out_valid[0]), 64'd0);
    chk("mid_rst_type", 64'(type_o[0]), 64'd0);
    chk("mid_rst_illegal", 64'(illegal[0]), 64'd0);
    chk("mid_rst_tag", 64'(tag_o[0]), 64'd0);
    chk("mid_rst_cnt0", 64'(cnt0), 64'd0);
    q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready[0]), 64'd1);
    out_ready[0] = 1'b1;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
